// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and IF/ID register with reset/interrupt vector loads, stall, flush and one-level interrupt masking
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              imm_en_in,
  output logic [ADDR_W-1:0] addr_instr,
  output logic              intr_ack,
  input  logic              intr,
  input  logic              rti,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_imm,
  output logic              if_imm_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_next_pc,
  output logic [ADDR_W-1:0] irq_ret_pc
);
  typedef enum logic [1:0] {RUN, VEC, ISR} state_t;
  state_t state, state_n;
  logic pending, pend_n, accept, fetch, bubble;
  logic [ADDR_W-1:0] pc, pc_n, ret_n, next_pc;
  assign addr_instr = pc;
  assign next_pc = pc + (imm_en_in ? ADDR_W'(2) : ADDR_W'(1));
  always_comb begin
    accept = state == RUN && !flush && !stall && (pending || intr);
    fetch = state != VEC && !flush && !stall && !accept;
    bubble = state == VEC || flush || accept;
    state_n = state == VEC ? ISR : accept ? VEC : (state == ISR && rti) ? RUN : state;
    pc_n = state == VEC ? ADDR_W'(instr_in) : flush ? branch_target : fetch ? next_pc : pc;
    ret_n = (state == VEC && flush) ? branch_target : accept ? pc : irq_ret_pc;
    pend_n = accept ? 1'b0 : pending || intr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= ADDR_W'(instr_in);
      state <= RUN;
      pending <= 1'b0;
      intr_ack <= 1'b0;
      irq_ret_pc <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_imm <= '0;
      if_imm_valid <= 1'b0;
      if_pc <= '0;
      if_next_pc <= '0;
    end else begin
      pc <= pc_n;
      state <= state_n;
      pending <= pend_n;
      intr_ack <= state_n == VEC;
      irq_ret_pc <= ret_n;
      if (bubble) begin
        if_valid <= 1'b0;
        if_instr <= '0;
        if_imm <= '0;
        if_imm_valid <= 1'b0;
        if_pc <= '0;
        if_next_pc <= '0;
      end else if (fetch) begin
        if_valid <= 1'b1;
        if_instr <= instr_in;
        if_imm <= imm_en_in ? imm_in : '0;
        if_imm_valid <= imm_en_in;
        if_pc <= pc;
        if_next_pc <= next_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors against a byte-array memory model
module tb_fetch_unit;
  logic clk = 0, rst = 1, intr = 0, rti = 0, stall = 0, flush = 0;
  logic [7:0] branch_target = 0;
  logic [7:0] instr_in, imm_in, addr_instr, if_instr, if_imm, if_pc, if_next_pc, irq_ret_pc;
  logic imm_en_in, intr_ack, if_valid, if_imm_valid;
  logic [7:0] mem [256];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign instr_in = rst ? mem[0] : intr_ack ? mem[1] : mem[addr_instr];
  assign imm_in = mem[8'(addr_instr + 8'd1)];
  assign imm_en_in = mem[addr_instr][7:4] == 4'hC;
  fetch_unit dut (.clk(clk), .rst(rst), .instr_in(instr_in), .imm_in(imm_in), .imm_en_in(imm_en_in),
    .addr_instr(addr_instr), .intr_ack(intr_ack), .intr(intr), .rti(rti), .stall(stall), .flush(flush),
    .branch_target(branch_target), .if_valid(if_valid), .if_instr(if_instr), .if_imm(if_imm),
    .if_imm_valid(if_imm_valid), .if_pc(if_pc), .if_next_pc(if_next_pc), .irq_ret_pc(irq_ret_pc));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
    mem[8'h10] = 8'hC3; mem[8'h11] = 8'h5A; mem[8'h12] = 8'h21;
    mem[8'h40] = 8'h31;
    mem[8'h80] = 8'h01; mem[8'h81] = 8'h02; mem[8'h82] = 8'h03;
    mem[8'hFE] = 8'hC9; mem[8'hFF] = 8'hC7;
    step(); step();
    chk("rst_addr", addr_instr, 8'h10);
    chk("rst_valid", if_valid, 0);
    chk("rst_ack", intr_ack, 0);
    rst = 0;
    step();
    chk("two_instr", if_instr, 8'hC3);
    chk("two_imm", if_imm, 8'h5A);
    chk("two_immv", if_imm_valid, 1);
    chk("two_pc", if_pc, 8'h10);
    chk("two_next", if_next_pc, 8'h12);
    chk("two_addr", addr_instr, 8'h12);
    step();
    chk("one_instr", if_instr, 8'h21);
    chk("one_imm", if_imm, 0);
    chk("one_immv", if_imm_valid, 0);
    chk("one_addr", addr_instr, 8'h13);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", addr_instr, 8'h13);
      chk("stall_ifpc", if_pc, 8'h12);
      chk("stall_valid", if_valid, 1);
    end
    flush = 1; branch_target = 8'h40;
    step();
    chk("flush_addr", addr_instr, 8'h40);
    chk("flush_valid", if_valid, 0);
    flush = 0; stall = 0;
    step();
    chk("tgt_instr", if_instr, 8'h31);
    chk("tgt_addr", addr_instr, 8'h41);
    intr = 1;
    step();
    intr = 0;
    chk("acc_ack", intr_ack, 1);
    chk("acc_ret", irq_ret_pc, 8'h41);
    chk("acc_addr", addr_instr, 8'h41);
    chk("acc_valid", if_valid, 0);
    step();
    chk("vec_addr", addr_instr, 8'h80);
    chk("vec_ack", intr_ack, 0);
    chk("vec_valid", if_valid, 0);
    intr = 1;
    step();
    intr = 0;
    chk("isr_instr", if_instr, 8'h01);
    chk("isr_addr", addr_instr, 8'h81);
    chk("isr_mask", intr_ack, 0);
    step();
    chk("isr_held", intr_ack, 0);
    chk("isr_addr2", addr_instr, 8'h82);
    rti = 1;
    step();
    rti = 0;
    chk("rti_instr", if_instr, 8'h03);
    chk("rti_addr", addr_instr, 8'h83);
    chk("rti_ack", intr_ack, 0);
    step();
    chk("acc2_ack", intr_ack, 1);
    chk("acc2_ret", irq_ret_pc, 8'h83);
    flush = 1; branch_target = 8'h50;
    step();
    flush = 0;
    chk("vflush_ret", irq_ret_pc, 8'h50);
    chk("vflush_addr", addr_instr, 8'h80);
    chk("vflush_valid", if_valid, 0);
    flush = 1; branch_target = 8'hFF;
    step();
    flush = 0;
    chk("ff_addr", addr_instr, 8'hFF);
    step();
    chk("wrap2_imm", if_imm, 8'h10);
    chk("wrap2_next", if_next_pc, 8'h01);
    chk("wrap2_addr", addr_instr, 8'h01);
    flush = 1; branch_target = 8'hFE;
    step();
    flush = 0;
    step();
    chk("fe_imm", if_imm, 8'hC7);
    chk("fe_addr", addr_instr, 8'h00);
    mem[8'hFF] = 8'h44;
    flush = 1; branch_target = 8'hFF;
    step();
    flush = 0;
    step();
    chk("wrap1_instr", if_instr, 8'h44);
    chk("wrap1_addr", addr_instr, 8'h00);
    intr = 1;
    step();
    intr = 0;
    chk("isr_nacc", intr_ack, 0);
    chk("isr_nacc_addr", addr_instr, 8'h01);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_addr", addr_instr, 8'h10);
    chk("mrst_valid", if_valid, 0);
    chk("mrst_instr", if_instr, 0);
    chk("mrst_pc", if_pc, 0);
    chk("mrst_ret", irq_ret_pc, 0);
    chk("mrst_ack", intr_ack, 0);
    step();
    chk("post_ack", intr_ack, 0);
    chk("post_addr", addr_instr, 8'h12);
    chk("post_instr", if_instr, 8'hC3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
